// File: rtl/fifos_pkg.sv
// Packet widths, request/response type encodings and control-field packing
// shared by the master request engine and its tag tracker.
package fifos_pkg;
    localparam int DATA_LINE_WIDTH    = 64;
    localparam int CONTROL_LINE_WIDTH = 6;
    localparam int PACKET_WIDTH       = DATA_LINE_WIDTH + CONTROL_LINE_WIDTH;
    localparam int TAG_WIDTH          = 4;
    localparam int NUM_TAGS           = 16;
    localparam int COUNT_WIDTH        = 5;

    typedef enum logic [1:0] {
        REQ_INVALID = 2'b00,
        REQ_RD_ADDR = 2'b01,
        REQ_WR_ADDR = 2'b10,
        REQ_WR_DATA = 2'b11
    } req_type_e;

    typedef enum logic [1:0] {
        RSP_INVALID  = 2'b00,
        RSP_RD_DATA  = 2'b01,
        RSP_WR_ACK   = 2'b10,
        RSP_RESERVED = 2'b11
    } rsp_type_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_SEND_ADDR = 2'b01,
        ST_SEND_DATA = 2'b10
    } send_state_e;

    function automatic logic [CONTROL_LINE_WIDTH-1:0] pack_ctrl(
        input logic [1:0]           typ,
        input logic [TAG_WIDTH-1:0] tag
    );
        return {typ, tag};
    endfunction
endpackage

// File: rtl/master_req_engine_if.sv
// Core request/response handshake plus send/receive FIFO port bundle.
// The master modport is the engine side; slave is the core/FIFO side.
interface master_req_engine_if;
    import fifos_pkg::*;

    logic                          i_req_valid;
    logic                          o_req_ready;
    logic                          i_req_write;
    logic [DATA_LINE_WIDTH-1:0]    i_req_addr;
    logic [DATA_LINE_WIDTH-1:0]    i_req_wdata;
    logic [TAG_WIDTH-1:0]          o_req_tag;
    logic [PACKET_WIDTH-1:0]       o_sreq_inbits;
    logic                          o_sreq_wen;
    logic                          i_sreq_full;
    logic                          o_rresp_ren;
    logic [PACKET_WIDTH-1:0]       i_rresp_outbits;
    logic                          i_rresp_empty;
    logic                          o_resp_valid;
    logic                          i_resp_ready;
    logic                          o_resp_write;
    logic [TAG_WIDTH-1:0]          o_resp_tag;
    logic [DATA_LINE_WIDTH-1:0]    o_resp_data;
    logic [COUNT_WIDTH-1:0]        o_outstanding;
    logic                          o_err_unexpected;

    modport master (
        input  i_req_valid, i_req_write, i_req_addr, i_req_wdata,
        input  i_sreq_full, i_rresp_outbits, i_rresp_empty, i_resp_ready,
        output o_req_ready, o_req_tag, o_sreq_inbits, o_sreq_wen, o_rresp_ren,
        output o_resp_valid, o_resp_write, o_resp_tag, o_resp_data,
        output o_outstanding, o_err_unexpected
    );

    modport slave (
        output i_req_valid, i_req_write, i_req_addr, i_req_wdata,
        output i_sreq_full, i_rresp_outbits, i_rresp_empty, i_resp_ready,
        input  o_req_ready, o_req_tag, o_sreq_inbits, o_sreq_wen, o_rresp_ren,
        input  o_resp_valid, o_resp_write, o_resp_tag, o_resp_data,
        input  o_outstanding, o_err_unexpected
    );
endinterface

// File: rtl/master_req_engine_tag_tracker.sv
// Outstanding-tag scoreboard: busy bit per tag, in-flight count and a sticky
// flag for responses that match no outstanding tag or carry a bad type.
module tag_tracker
    import fifos_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_set_en,
    input  logic [TAG_WIDTH-1:0]   i_set_tag,
    input  logic                   i_clr_en,
    input  logic [TAG_WIDTH-1:0]   i_clr_tag,
    input  logic                   i_clr_bad,
    output logic [NUM_TAGS-1:0]    o_busy_vec,
    output logic [COUNT_WIDTH-1:0] o_count,
    output logic                   o_err
);
    logic [NUM_TAGS-1:0]    r_busy;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_err;
    logic                   w_clr_hit;

    // A bad-type response never retires a tag, even if the tag is busy.
    assign w_clr_hit = i_clr_en && !i_clr_bad && r_busy[i_clr_tag];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (i_set_en) begin
                r_busy[i_set_tag] <= 1'b1;
            end
            if (w_clr_hit) begin
                r_busy[i_clr_tag] <= 1'b0;
            end
            case ({i_set_en, w_clr_hit})
                2'b10:   r_count <= r_count + COUNT_WIDTH'(1);
                2'b01:   r_count <= r_count - COUNT_WIDTH'(1);
                default: r_count <= r_count;
            endcase
            if (i_clr_en && !w_clr_hit) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_busy_vec = r_busy;
    assign o_count    = r_count;
    assign o_err      = r_err;
endmodule

// File: rtl/master_req_engine.sv
// Formats core requests into address/data packets for the send FIFO and
// drains the response FIFO into a one-entry response register for the core.
//   state     | meaning
//   IDLE      | ready for a request if next tag is free
//   SEND_ADDR | address packet offered to send FIFO
//   SEND_DATA | write-data packet offered to send FIFO
module master_req_engine
    import fifos_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    master_req_engine_if.master bus
);
    send_state_e                r_state;
    send_state_e                w_state_nxt;
    logic [TAG_WIDTH-1:0]       r_next_tag;
    logic [TAG_WIDTH-1:0]       r_tag;
    logic                       r_write;
    logic [DATA_LINE_WIDTH-1:0] r_wdata;
    logic [PACKET_WIDTH-1:0]    r_pkt;
    logic                       w_req_ready;
    logic                       w_accept;
    logic                       w_sreq_wen;
    logic                       w_set_en;
    logic [NUM_TAGS-1:0]        w_busy;
    logic [COUNT_WIDTH-1:0]     w_count;
    logic                       w_err;

    logic                       r_rd_pending;
    logic                       r_resp_valid;
    logic                       r_resp_write;
    logic [TAG_WIDTH-1:0]       r_resp_tag;
    logic [DATA_LINE_WIDTH-1:0] r_resp_data;
    logic                       w_rresp_ren;
    rsp_type_e                  w_rsp_type;
    logic [TAG_WIDTH-1:0]       w_rsp_tag;
    logic                       w_rsp_bad;

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 1'b0;
        w_accept    = 1'b0;
        w_sreq_wen  = 1'b0;
        w_set_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = !w_busy[r_next_tag];
                if (bus.i_req_valid && w_req_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SEND_ADDR;
                end
            end
            ST_SEND_ADDR: begin
                w_sreq_wen = !bus.i_sreq_full;
                if (w_sreq_wen) begin
                    w_set_en    = 1'b1;
                    w_state_nxt = r_write ? ST_SEND_DATA : ST_IDLE;
                end
            end
            ST_SEND_DATA: begin
                w_sreq_wen = !bus.i_sreq_full;
                if (w_sreq_wen) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_next_tag <= '0;
            r_tag      <= '0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_pkt      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_tag      <= r_next_tag;
                r_next_tag <= r_next_tag + TAG_WIDTH'(1);
                r_write    <= bus.i_req_write;
                r_wdata    <= bus.i_req_wdata;
                r_pkt      <= {pack_ctrl(bus.i_req_write ? REQ_WR_ADDR : REQ_RD_ADDR, r_next_tag),
                               bus.i_req_addr};
            end else if (r_state == ST_SEND_ADDR && w_sreq_wen && r_write) begin
                r_pkt <= {pack_ctrl(REQ_WR_DATA, r_tag), r_wdata};
            end
        end
    end

    // Only one FIFO read in flight, and only when the response register is free
    // (or being emptied this cycle), so a captured response is never overwritten.
    assign w_rresp_ren = !bus.i_rresp_empty && !r_rd_pending && (!r_resp_valid || bus.i_resp_ready);
    assign w_rsp_type  = rsp_type_e'(bus.i_rresp_outbits[PACKET_WIDTH-1 -: 2]);
    assign w_rsp_tag   = bus.i_rresp_outbits[DATA_LINE_WIDTH +: TAG_WIDTH];
    assign w_rsp_bad   = (w_rsp_type != RSP_RD_DATA) && (w_rsp_type != RSP_WR_ACK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pending <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_write <= 1'b0;
            r_resp_tag   <= '0;
            r_resp_data  <= '0;
        end else begin
            r_rd_pending <= w_rresp_ren;
            if (r_rd_pending) begin
                r_resp_valid <= 1'b1;
                r_resp_write <= (w_rsp_type == RSP_WR_ACK);
                r_resp_tag   <= w_rsp_tag;
                r_resp_data  <= (w_rsp_type == RSP_RD_DATA) ?
                                bus.i_rresp_outbits[DATA_LINE_WIDTH-1:0] : '0;
            end else if (r_resp_valid && bus.i_resp_ready) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

    tag_tracker u_tag_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_set_en   (w_set_en),
        .i_set_tag  (r_tag),
        .i_clr_en   (r_rd_pending),
        .i_clr_tag  (w_rsp_tag),
        .i_clr_bad  (w_rsp_bad),
        .o_busy_vec (w_busy),
        .o_count    (w_count),
        .o_err      (w_err)
    );

    assign bus.o_req_ready      = w_req_ready;
    assign bus.o_req_tag        = r_next_tag;
    assign bus.o_sreq_inbits    = r_pkt;
    assign bus.o_sreq_wen       = w_sreq_wen;
    assign bus.o_rresp_ren      = w_rresp_ren;
    assign bus.o_resp_valid     = r_resp_valid;
    assign bus.o_resp_write     = r_resp_write;
    assign bus.o_resp_tag       = r_resp_tag;
    assign bus.o_resp_data      = r_resp_data;
    assign bus.o_outstanding    = w_count;
    assign bus.o_err_unexpected = w_err;
endmodule

// File: tb/tb_master_req_engine.sv
// Directed bench for master_req_engine: request vector table plus hand-written
// response, backpressure, unexpected-tag and mid-transaction reset sequences.
module tb_master_req_engine;
    logic clk;
    logic rst_n;
    int   n_run;
    int   n_fail;
    int   n_push;
    int   n_pop;
    logic [69:0] rmem [64];

    master_req_engine_if bus ();

    master_req_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        write;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          full_cyc;
        logic [3:0]  exp_tag;
        logic [69:0] exp_apkt;
        logic [69:0] exp_dpkt;
        logic [4:0]  exp_out;
    } req_vec_t;

    req_vec_t vecs [4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Response FIFO model: single writer per variable, pops one entry per ren.
    assign bus.i_rresp_empty = (n_push == n_pop);

    always @(posedge clk) begin
        if (bus.o_rresp_ren) begin
            #1;
            bus.i_rresp_outbits = rmem[n_pop[5:0]];
            n_pop = n_pop + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_resp(input logic [69:0] pkt);
        rmem[n_push[5:0]] = pkt;
        n_push = n_push + 1;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 20; i++) begin
            step();
            #1;
            if (bus.o_resp_valid) break;
        end
        chk(name, 70'(bus.o_resp_valid), 70'(1));
    endtask

    task automatic issue(input logic wr, input logic [63:0] addr, input logic [63:0] wd);
        bus.i_req_valid = 1'b1;
        bus.i_req_write = wr;
        bus.i_req_addr  = addr;
        bus.i_req_wdata = wd;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.o_req_ready) break;
            step();
        end
        chk("issue_ready", 70'(bus.o_req_ready), 70'(1));
        step();
        bus.i_req_valid = 1'b0;
        step();
        if (wr) step();
    endtask

    initial begin
        int snap;
        n_run  = 0;
        n_fail = 0;
        n_push = 0;
        n_pop  = 0;
        rst_n  = 1'b0;
        bus.i_req_valid  = 1'b0;
        bus.i_req_write  = 1'b0;
        bus.i_req_addr   = '0;
        bus.i_req_wdata  = '0;
        bus.i_sreq_full  = 1'b0;
        bus.i_resp_ready = 1'b1;

        vecs[0] = '{1'b0, 64'h1000, 64'h0, 0, 4'h0,
                    {2'b01, 4'h0, 64'h1000}, 70'h0, 5'd1};
        vecs[1] = '{1'b1, 64'h20, 64'hDEAD, 3, 4'h1,
                    {2'b10, 4'h1, 64'h20}, {2'b11, 4'h1, 64'hDEAD}, 5'd2};
        vecs[2] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 1, 4'h2,
                    {2'b01, 4'h2, 64'hFFFF_FFFF_FFFF_FFF0}, 70'h0, 5'd3};
        vecs[3] = '{1'b1, 64'h8, 64'hA5A5_5A5A_0123_4567, 0, 4'h3,
                    {2'b10, 4'h3, 64'h8}, {2'b11, 4'h3, 64'hA5A5_5A5A_0123_4567}, 5'd4};

        @(negedge clk);
        #1;
        chk("rst_wen",       70'(bus.o_sreq_wen),       70'(0));
        chk("rst_inbits",    bus.o_sreq_inbits,         70'(0));
        chk("rst_ren",       70'(bus.o_rresp_ren),      70'(0));
        chk("rst_resp_v",    70'(bus.o_resp_valid),     70'(0));
        chk("rst_out",       70'(bus.o_outstanding),    70'(0));
        chk("rst_err",       70'(bus.o_err_unexpected), 70'(0));
        chk("rst_ready",     70'(bus.o_req_ready),      70'(1));
        chk("rst_tag",       70'(bus.o_req_tag),        70'(0));
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 4; v++) begin
            bus.i_req_valid = 1'b1;
            bus.i_req_write = vecs[v].write;
            bus.i_req_addr  = vecs[v].addr;
            bus.i_req_wdata = vecs[v].wdata;
            #1;
            chk("vec_ready", 70'(bus.o_req_ready), 70'(1));
            chk("vec_tag",   70'(bus.o_req_tag),   70'(vecs[v].exp_tag));
            step();
            bus.i_req_valid = 1'b0;
            bus.i_sreq_full = (vecs[v].full_cyc > 0);
            for (int k = 0; k < vecs[v].full_cyc; k++) begin
                #1;
                chk("vec_full_wen",  70'(bus.o_sreq_wen), 70'(0));
                chk("vec_full_hold", bus.o_sreq_inbits,   vecs[v].exp_apkt);
                step();
            end
            bus.i_sreq_full = 1'b0;
            #1;
            chk("vec_addr_wen", 70'(bus.o_sreq_wen), 70'(1));
            chk("vec_addr_pkt", bus.o_sreq_inbits,   vecs[v].exp_apkt);
            step();
            if (vecs[v].write) begin
                #1;
                chk("vec_data_wen", 70'(bus.o_sreq_wen), 70'(1));
                chk("vec_data_pkt", bus.o_sreq_inbits,   vecs[v].exp_dpkt);
                step();
            end
            #1;
            chk("vec_outstanding", 70'(bus.o_outstanding), 70'(vecs[v].exp_out));
            chk("vec_idle_wen",    70'(bus.o_sreq_wen),    70'(0));
        end

        // Fill all 16 tags with reads; no response yet.
        for (int t = 4; t < 16; t++) begin
            issue(1'b0, 64'h4000 + 64'(t), 64'h0);
        end
        #1;
        chk("full_outstanding", 70'(bus.o_outstanding), 70'(16));
        chk("full_ready",       70'(bus.o_req_ready),   70'(0));

        push_resp({2'b01, 4'h0, 64'h55});
        wait_valid("rsp0_valid");
        chk("rsp0_tag",   70'(bus.o_resp_tag),    70'(0));
        chk("rsp0_data",  70'(bus.o_resp_data),   70'(64'h55));
        chk("rsp0_write", 70'(bus.o_resp_write),  70'(0));
        chk("rsp0_out",   70'(bus.o_outstanding), 70'(15));
        chk("rsp0_ready", 70'(bus.o_req_ready),   70'(1));
        step();
        #1;
        chk("rsp0_drain", 70'(bus.o_resp_valid), 70'(0));

        // Backpressure: one read issued, register holds until ready returns.
        bus.i_resp_ready = 1'b0;
        snap = n_pop;
        push_resp({2'b10, 4'h1, 64'hFFFF});
        push_resp({2'b01, 4'h2, 64'hBEEF});
        wait_valid("bp_valid");
        for (int i = 0; i < 6; i++) step();
        #1;
        chk("bp_one_ren",  70'(n_pop - snap),      70'(1));
        chk("bp_ren_low",  70'(bus.o_rresp_ren),   70'(0));
        chk("bp_hold_v",   70'(bus.o_resp_valid),  70'(1));
        chk("bp_hold_tag", 70'(bus.o_resp_tag),    70'(1));
        chk("bp_hold_wr",  70'(bus.o_resp_write),  70'(1));
        chk("bp_hold_dat", 70'(bus.o_resp_data),   70'(0));
        bus.i_resp_ready = 1'b1;
        #1;
        chk("bp_release_ren", 70'(bus.o_rresp_ren), 70'(1));
        wait_valid("bp2_valid");
        chk("bp2_tag",  70'(bus.o_resp_tag),    70'(2));
        chk("bp2_data", 70'(bus.o_resp_data),   70'(64'hBEEF));
        chk("bp2_wr",   70'(bus.o_resp_write),  70'(0));
        chk("bp2_out",  70'(bus.o_outstanding), 70'(13));
        chk("bp2_rens", 70'(n_pop - snap),      70'(2));

        // Retire tag 7, then a second response for it is unexpected.
        push_resp({2'b01, 4'h7, 64'h77});
        wait_valid("t7_valid");
        chk("t7_data", 70'(bus.o_resp_data),      70'(64'h77));
        chk("t7_out",  70'(bus.o_outstanding),    70'(12));
        chk("t7_err",  70'(bus.o_err_unexpected), 70'(0));
        push_resp({2'b10, 4'h7, 64'h1234});
        wait_valid("unx_valid");
        chk("unx_tag",  70'(bus.o_resp_tag),       70'(7));
        chk("unx_wr",   70'(bus.o_resp_write),     70'(1));
        chk("unx_data", 70'(bus.o_resp_data),      70'(0));
        chk("unx_err",  70'(bus.o_err_unexpected), 70'(1));
        chk("unx_out",  70'(bus.o_outstanding),    70'(12));
        push_resp({2'b00, 4'h3, 64'h99});
        wait_valid("bad_valid");
        chk("bad_out",  70'(bus.o_outstanding), 70'(12));
        chk("bad_data", 70'(bus.o_resp_data),   70'(0));
        for (int i = 0; i < 4; i++) step();
        #1;
        chk("err_sticky", 70'(bus.o_err_unexpected), 70'(1));

        // Reset while the write-data packet is pending.
        bus.i_req_valid = 1'b1;
        bus.i_req_write = 1'b1;
        bus.i_req_addr  = 64'h40;
        bus.i_req_wdata = 64'h99;
        #1;
        chk("mr_ready", 70'(bus.o_req_ready), 70'(1));
        chk("mr_tag",   70'(bus.o_req_tag),   70'(0));
        step();
        bus.i_req_valid = 1'b0;
        step();
        #1;
        chk("mr_data_pkt", bus.o_sreq_inbits,      {2'b11, 4'h0, 64'h99});
        chk("mr_out",      70'(bus.o_outstanding), 70'(13));
        rst_n = 1'b0;
        #1;
        chk("mr_rst_wen",   70'(bus.o_sreq_wen),       70'(0));
        chk("mr_rst_pkt",   bus.o_sreq_inbits,         70'(0));
        chk("mr_rst_out",   70'(bus.o_outstanding),    70'(0));
        chk("mr_rst_err",   70'(bus.o_err_unexpected), 70'(0));
        chk("mr_rst_rv",    70'(bus.o_resp_valid),     70'(0));
        chk("mr_rst_rtag",  70'(bus.o_resp_tag),       70'(0));
        chk("mr_rst_rdata", 70'(bus.o_resp_data),      70'(0));
        chk("mr_rst_ready", 70'(bus.o_req_ready),      70'(1));
        chk("mr_rst_tag",   70'(bus.o_req_tag),        70'(0));
        step();
        rst_n = 1'b1;
        step();
        bus.i_req_valid = 1'b1;
        bus.i_req_write = 1'b0;
        bus.i_req_addr  = 64'h300;
        #1;
        chk("post_tag", 70'(bus.o_req_tag), 70'(0));
        step();
        bus.i_req_valid = 1'b0;
        #1;
        chk("post_wen", 70'(bus.o_sreq_wen), 70'(1));
        chk("post_pkt", bus.o_sreq_inbits,   {2'b01, 4'h0, 64'h300});
        step();
        #1;
        chk("post_out", 70'(bus.o_outstanding), 70'(1));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/master_req_engine.md
# master_req_engine

Master-core transaction engine that sits directly upstream of the request/response FIFO interface. It accepts read/write requests from the master core and formats them into 70-bit packets (64 data + 6 control) for the send-request FIFO. It drains the receive-response FIFO, matches each response to an outstanding tag and returns the result to the core.

## Interface
- DATA_LINE_WIDTH, 64, payload width of a packet
- CONTROL_LINE_WIDTH, 6, control width: {type[1:0], tag[3:0]}
- NUM_TAGS, 16, outstanding-transaction limit; must equal 2^4
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_req_valid  in  1  core request valid
- o_req_ready  out  1  request accepted when valid&&ready
- i_req_write  in  1  1 = write, 0 = read
- i_req_addr  in  64  request address
- i_req_wdata  in  64  write data, ignored for reads
- o_req_tag  out  4  tag assigned to the request being accepted
- o_sreq_inbits  out  70  packet to send-request FIFO, {control, data}
- o_sreq_wen  out  1  send-request FIFO write enable
- i_sreq_full  in  1  send-request FIFO full
- o_rresp_ren  out  1  receive-response FIFO read enable
- i_rresp_outbits  in  70  response packet, valid one cycle after ren
- i_rresp_empty  in  1  receive-response FIFO empty
- o_resp_valid  out  1  response to core valid
- i_resp_ready  in  1  core accepts response
- o_resp_write  out  1  1 = write ack, 0 = read data
- o_resp_tag  out  4  tag of the response
- o_resp_data  out  64  read data; 0 for write acks
- o_outstanding  out  5  count of in-flight tags, 0..16
- o_err_unexpected  out  1  sticky: a response arrived for a tag that is not outstanding

## Operation
- Request packet types: 01 RD_ADDR, 10 WR_ADDR, 11 WR_DATA. Response types: 01 RD_DATA, 10 WR_ACK. Type 00 is invalid and sets o_err_unexpected.
- Send FSM states:
  - IDLE: o_req_ready = !busy[next_tag]. On accept, register write/addr/wdata, set tag = next_tag, advance next_tag by 1 (4-bit wrap 15→0), go to SEND_ADDR.
  - SEND_ADDR: drive {RD_ADDR|WR_ADDR, tag, addr}, with o_sreq_wen = !i_sreq_full. On write, set busy[tag] and increment the count. Go to SEND_DATA if the request is a write, otherwise IDLE.
  - SEND_DATA: drive {WR_DATA, tag, wdata}, with o_sreq_wen = !i_sreq_full. On write, go to IDLE.
- o_sreq_wen is never asserted while i_sreq_full = 1. The packet is held stable until it is written.
- Response path:
  - o_rresp_ren = !i_rresp_empty && !rd_pending && (!o_resp_valid || i_resp_ready).
  - rd_pending is ren delayed by one cycle. While rd_pending is set, i_rresp_outbits is captured into the output register: o_resp_valid goes to 1, and busy[tag] is cleared while the count decrements.
  - A response for a non-busy tag or an invalid type sets o_err_unexpected. It is still presented to the core, and the count is not changed.
- The output register holds while o_resp_valid && !i_resp_ready.
- Set and clear of busy[] in the same cycle always target different tags. A simultaneous increment and decrement leaves the count unchanged.
- o_err_unexpected is cleared only by reset.

## Timing
- Reset values:
  - FSM = IDLE, next_tag = 0, busy = 0, count = 0, rd_pending = 0.
  - All registered outputs are 0: o_sreq_wen, o_sreq_inbits, o_rresp_ren, o_resp_*, o_outstanding, o_err_unexpected.
  - o_req_ready is 1 (IDLE, tag 0 free), and o_req_tag is 0.
- Reset asserted mid-transaction abandons any partially sent request: FSM returns to IDLE and all tags are freed.
- Send latency, with the FIFO not full:
  - Accept at edge N; address packet written at edge N+1.
  - For writes, data packet written at edge N+2.
  - Peak rate: one read per 2 cycles, one write per 3 cycles.
- Response latency: ren at edge N; o_resp_valid = 1 after edge N+1. Peak rate is one response per 2 cycles.
- o_outstanding updates on the edge at which the address packet is written or the response is captured.

## Structure
- fifos_pkg holds:
  - packet width constants;
  - request/response type encodings;
  - the control-field packing function, {type, tag}.
- Sub-module tag_tracker contains busy[NUM_TAGS], the count and the unexpected-tag check. Its ports are set_en/set_tag, clr_en/clr_tag, busy_vec, count and err.
- The FSM and response register live in master_req_engine.

## Test plan
- Read request, addr 0x1000, FIFO not full → at edge N+1 o_sreq_inbits = {2'b01, 4'h0, 64'h1000}, wen = 1; o_outstanding becomes 1 and o_req_tag = 0.
- Write request, addr 0x20, wdata 0xDEAD, with i_sreq_full = 1 for 3 cycles → wen stays 0 and the packet holds. Then {10,tag,0x20} and {11,tag,0xDEAD} are written on consecutive edges.
- Issue 16 reads with no responses → o_outstanding = 16 and o_req_ready = 0. Return a RD_DATA for tag 0 with data 0x55 → o_resp_valid, tag 0, data 0x55; o_req_ready returns to 1.
- Hold i_resp_ready = 0 with the response FIFO non-empty → exactly one ren is issued and o_resp holds stable. Release ready → the next ren is issued in the same cycle.
- Inject a WR_ACK for a non-busy tag 7 → o_err_unexpected = 1 and stays set; o_outstanding is unchanged.
- Assert rst_n = 0 during SEND_DATA → all outputs are 0 immediately, o_req_ready = 1, and the next accepted request gets tag 0.
